mips_dmem_io: RTL and testbench

Data-memory stage for the pipelined MIPS core: it consumes the memory-stage outputs (`memwrite`, ALU address, store data) and returns load data in the same cycle. The address space is split into a word-addressed RAM and a small memory-mapped I/O window. The window contains an LED register, a free-running cycle counter and a byte transmit FIFO with a valid/ready output handshake. The block sits directly downstream of the core's memory stage in the top-level system.

---
 rtl/mips_dmem_io.sv | 174 +++++++++++++++++
 tb/tb_mips_dmem_io.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_dmem_io.sv
`default_nettype none
// ============================================================================
//  Module      : mips_dmem_io
//  Description : Data-memory stage for the pipelined MIPS core. Word RAM plus
//                an MMIO window holding an LED register, a free-running cycle
//                counter and a byte TX FIFO with a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_dmem_io #(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [15:0] led,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;
    localparam logic [CW-1:0] C_FULL_COUNT = CW'(FIFO_DEPTH);

    localparam logic [1:0] C_REG_LED    = 2'd0;
    localparam logic [1:0] C_REG_CYCLES = 2'd1;
    localparam logic [1:0] C_REG_TXDATA = 2'd2;
    localparam logic [1:0] C_REG_TXSTAT = 2'd3;

    // Storage and state
    logic [31:0]   r_ram [0:RAM_WORDS-1];
    logic [7:0]    r_fifo [0:FIFO_DEPTH-1];
    logic [15:0]   r_led;
    logic [31:0]   r_cycles;
    logic [FW-1:0] r_rptr;
    logic [FW-1:0] r_wptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    // Decode
    logic          w_sel_ram;
    logic          w_sel_io;
    logic [AW-1:0] w_ram_idx;
    logic          w_io_wr;
    logic          w_led_wr;
    logic          w_cyc_clr;
    logic          w_push;
    logic          w_stat_clr;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_ovf_set;
    logic [31:0]   w_stat;
    logic          w_unused_addr;

    assign w_sel_ram  = ~addr[31];
    assign w_sel_io   = (addr[31:4] == 28'hFFFF000);
    assign w_ram_idx  = addr[AW+1:2];
    assign w_io_wr    = memwrite & w_sel_io;
    assign w_led_wr   = w_io_wr & (addr[3:2] == C_REG_LED);
    assign w_cyc_clr  = w_io_wr & (addr[3:2] == C_REG_CYCLES);
    assign w_push     = w_io_wr & (addr[3:2] == C_REG_TXDATA);
    assign w_stat_clr = w_io_wr & (addr[3:2] == C_REG_TXSTAT);

    // Byte offset within a word carries no meaning here.
    assign w_unused_addr = ^addr[1:0];

    // FIFO handshake: everything is derived from registered state only, so
    // tx_valid/tx_data never depend combinationally on tx_ready.
    assign w_full    = (r_count == C_FULL_COUNT);
    assign w_empty   = (r_count == '0);
    assign w_pop     = tx_valid & tx_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_ovf_set = w_push & w_full & ~w_pop;

    assign tx_valid = ~w_empty;
    assign tx_data  = r_fifo[r_rptr];
    assign led      = r_led;

    // TXSTAT layout: count above bit 4, then ovf/empty/full in bits 2..0
    always_comb begin
        w_stat           = '0;
        w_stat[4 +: CW]  = r_count;
        w_stat[2]        = r_ovf;
        w_stat[1]        = w_empty;
        w_stat[0]        = w_full;
    end

    // Load path: combinational read of RAM or MMIO, zero for unmapped space
    always_comb begin
        readdata = '0;
        if (w_sel_ram) begin
            readdata = r_ram[w_ram_idx];
        end else if (w_sel_io) begin
            case (addr[3:2])
                C_REG_LED:    readdata = {16'b0, r_led};
                C_REG_CYCLES: readdata = r_cycles;
                C_REG_TXDATA: readdata = '0;
                C_REG_TXSTAT: readdata = w_stat;
                default:      readdata = '0;
            endcase
        end
    end

    // RAM word store; contents survive reset
    always_ff @(posedge clk) begin
        if (memwrite && w_sel_ram) begin
            r_ram[w_ram_idx] <= writedata;
        end
    end

    // LED register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led <= '0;
        end else if (w_led_wr) begin
            r_led <= writedata[15:0];
        end
    end

    // Free-running cycle counter; a write clears it instead of incrementing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycles <= '0;
        end else if (w_cyc_clr) begin
            r_cycles <= '0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    // FIFO entry storage; stale entries are unreachable once pointers reset
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo[r_wptr] <= writedata[7:0];
        end
    end

    // FIFO pointers, occupancy count and sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + FW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + FW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_stat_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_dmem_io.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_dmem_io
//  Description : Directed self-checking bench for mips_dmem_io.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_dmem_io;

    localparam logic [31:0] A_LED    = 32'hFFFF0000;
    localparam logic [31:0] A_CYCLES = 32'hFFFF0004;
    localparam logic [31:0] A_TXDATA = 32'hFFFF0008;
    localparam logic [31:0] A_TXSTAT = 32'hFFFF000C;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [15:0] led;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int checks = 0;
    int errors = 0;

    mips_dmem_io #(
        .RAM_WORDS (256),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .memwrite (memwrite),
        .addr     (addr),
        .writedata(writedata),
        .readdata (readdata),
        .led      (led),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle store
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        addr      = a;
        writedata = d;
        tick();
        memwrite  = 1'b0;
        writedata = '0;
    endtask

    // Combinational load check
    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    initial begin
        reset     = 1'b1;
        memwrite  = 1'b0;
        addr      = '0;
        writedata = '0;
        tx_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        addr  = A_CYCLES;
        reset = 1'b0;

        // ---- reset state and counter progression
        rd("cyc0", A_CYCLES, 32'd0);
        tick(); rd("cyc1", A_CYCLES, 32'd1);
        tick(); rd("cyc2", A_CYCLES, 32'd2);
        tick(); rd("cyc3", A_CYCLES, 32'd3);
        chk("led_rst", {16'b0, led}, 32'd0);
        chk("txv_rst", {31'b0, tx_valid}, 32'd0);
        rd("stat_rst", A_TXSTAT, 32'h2);

        // ---- RAM store/load and aliasing
        wr(32'h40, 32'hDEADBEEF);
        wr(32'h44, 32'h12345678);
        rd("ram40", 32'h40, 32'hDEADBEEF);
        rd("ram44", 32'h44, 32'h12345678);
        rd("ram_alias", 32'h440, 32'hDEADBEEF);
        rd("ram_byteoff", 32'h43, 32'hDEADBEEF);
        // Same-cycle load sees the old word, next cycle the new one
        memwrite  = 1'b1;
        addr      = 32'h40;
        writedata = 32'hCAFEF00D;
        #1;
        chk("ram_old", readdata, 32'hDEADBEEF);
        tick();
        memwrite = 1'b0;
        rd("ram_new", 32'h40, 32'hCAFEF00D);

        // ---- LED and unmapped space
        wr(A_LED, 32'hABCD1234);
        chk("led", {16'b0, led}, 32'h1234);
        rd("led_rb", A_LED, 32'h00001234);
        wr(32'hFFFF0010, 32'hFFFFFFFF);
        rd("unmapped", 32'hFFFF0010, 32'd0);
        rd("unmapped_hi", 32'h80000000, 32'd0);
        chk("led_keep", {16'b0, led}, 32'h1234);
        rd("stat_keep", A_TXSTAT, 32'h2);
        rd("txdata_rd", A_TXDATA, 32'd0);

        // ---- FIFO fill and overflow
        tx_ready = 1'b0;
        wr(A_TXDATA, 32'h01);
        chk("txv_lat", {31'b0, tx_valid}, 32'd1);
        for (int i = 2; i <= 5; i++) wr(A_TXDATA, 32'(i));
        rd("stat_ovf", A_TXSTAT, 32'h45);
        tx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("drain_v", {31'b0, tx_valid}, 32'd1);
            chk("drain_d", {24'b0, tx_data}, 32'(i));
            tick();
        end
        tx_ready = 1'b0;
        chk("txv_empty", {31'b0, tx_valid}, 32'd0);
        rd("stat_drained", A_TXSTAT, 32'h6);
        wr(A_TXSTAT, 32'h0);
        rd("stat_clr", A_TXSTAT, 32'h2);

        // ---- push and pop together while full
        wr(A_TXDATA, 32'h10);
        wr(A_TXDATA, 32'h20);
        wr(A_TXDATA, 32'h30);
        wr(A_TXDATA, 32'h40);
        rd("stat_full", A_TXSTAT, 32'h41);
        memwrite  = 1'b1;
        addr      = A_TXDATA;
        writedata = 32'h55;
        tx_ready  = 1'b1;
        #1;
        chk("pp_head", {24'b0, tx_data}, 32'h10);
        tick();
        memwrite = 1'b0;
        tx_ready = 1'b0;
        rd("stat_pp", A_TXSTAT, 32'h41);
        tx_ready = 1'b1;
        chk("pp_d1", {24'b0, tx_data}, 32'h20); tick();
        chk("pp_d2", {24'b0, tx_data}, 32'h30); tick();
        chk("pp_d3", {24'b0, tx_data}, 32'h40); tick();
        chk("pp_d4", {24'b0, tx_data}, 32'h55);
        chk("pp_v4", {31'b0, tx_valid}, 32'd1); tick();
        tx_ready = 1'b0;
        chk("pp_empty", {31'b0, tx_valid}, 32'd0);

        // ---- counter clear and wrap
        wr(A_CYCLES, 32'h12345678);
        rd("cyc_clr", A_CYCLES, 32'd0);
        tick(); rd("cyc_clr1", A_CYCLES, 32'd1);
        force dut.r_cycles = 32'hFFFFFFFE;
        #1;
        release dut.r_cycles;
        rd("cyc_fe", A_CYCLES, 32'hFFFFFFFE);
        tick(); rd("cyc_ff", A_CYCLES, 32'hFFFFFFFF);
        tick(); rd("cyc_wrap", A_CYCLES, 32'd0);

        // ---- asynchronous reset with data in the FIFO
        wr(A_TXDATA, 32'hA1);
        wr(A_TXDATA, 32'hA2);
        rd("stat_two", A_TXSTAT, 32'h20);
        chk("txv_two", {31'b0, tx_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("txv_async", {31'b0, tx_valid}, 32'd0);
        rd("stat_async", A_TXSTAT, 32'h2);
        chk("led_async", {16'b0, led}, 32'd0);
        tick();
        reset = 1'b0;
        rd("ram_survive", 32'h44, 32'h12345678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
